// File: rtl/mod7_pkg.sv
// Shared state encoding, widths and the residue step for the mod-7 frame scheduler.
package mod7_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      REPORT = 2'd2
   } state_t;

   localparam int MODULUS   = 7;
   localparam int REM_W     = 3;
   localparam int DIV_CNT_W = 16;

   // 2*rem+bit never exceeds 13, so one conditional subtract keeps it in 0..6.
   function automatic logic [REM_W-1:0] rem_step(input logic [REM_W-1:0] rem, input logic b);
      logic [3:0] v_sum;
      v_sum = {rem, 1'b0} + {3'b000, b};
      if (v_sum >= 4'(MODULUS)) v_sum = v_sum - 4'(MODULUS);
      return v_sum[REM_W-1:0];
   endfunction

endpackage

// File: rtl/mod7_rr_arb.sv
// Combinational round-robin pick: first valid requester at or after i_ptr, wrapping.
module mod7_rr_arb
   import mod7_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] i_valid,
   input  logic [ID_W-1:0]    i_ptr,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [ID_W-1:0]    o_idx,
   output logic               o_any
);

   always_comb begin
      logic [ID_W-1:0] v_cand;
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      v_cand  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         v_cand = ID_W'((int'(i_ptr) + k) % NUM_REQ);
         if (!o_any && i_valid[v_cand]) begin
            o_grant[v_cand] = 1'b1;
            o_idx           = v_cand;
            o_any           = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mod7_frame_sched.sv
// Round-robin scheduler feeding one shared serial mod-7 residue engine.
// Build option MOD7_DIV_CNT_EN adds div_cnt, a saturating count of divisible results.
//
// state  | meaning
// IDLE   | waiting for any req_valid; grant is combinational
// SHIFT  | one word bit per cycle, MSB first, for WORD_W cycles
// REPORT | result presented; a handshake may grant the next word in the same cycle
module mod7_frame_sched
   import mod7_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   parameter  int WORD_W  = 16,
   localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*WORD_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      res_valid,
   input  logic                      res_ready,
   output logic [ID_W-1:0]           res_id,
   output logic [REM_W-1:0]          res_rem,
   output logic                      res_div,
   output logic                      busy
`ifdef MOD7_DIV_CNT_EN
   ,
   output logic [DIV_CNT_W-1:0]      div_cnt
`endif
);

   localparam int CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

   state_t              r_state;
   logic [ID_W-1:0]     r_ptr;
   logic [ID_W-1:0]     r_id;
   logic [WORD_W-1:0]   r_word;
   logic [CNT_W-1:0]    r_cnt;
   logic [REM_W-1:0]    r_rem;

   logic [NUM_REQ-1:0]  w_grant;
   logic [ID_W-1:0]     w_idx;
   logic [ID_W-1:0]     w_ptr_next;
   logic [WORD_W-1:0]   w_word;
   logic                w_any;
   logic                w_res_hs;
   logic                w_grant_en;
   logic                w_accept;

   mod7_rr_arb #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .i_valid (req_valid),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_any   (w_any)
   );

   // A result handshake reopens the arbiter in the same cycle for back-to-back frames.
   assign w_res_hs   = (r_state == REPORT) && res_ready;
   assign w_grant_en = (r_state == IDLE) || w_res_hs;
   assign req_ready  = w_grant_en ? w_grant : '0;
   assign w_accept   = w_grant_en && w_any;
   assign w_ptr_next = (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;

   always_comb begin
      w_word = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (w_idx == ID_W'(i)) w_word = req_data[i*WORD_W +: WORD_W];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_ptr   <= '0;
         r_id    <= '0;
         r_word  <= '0;
         r_cnt   <= '0;
         r_rem   <= '0;
      end else if (w_accept) begin
         r_state <= SHIFT;
         r_ptr   <= w_ptr_next;
         r_id    <= w_idx;
         r_word  <= w_word;
         r_cnt   <= CNT_W'(WORD_W - 1);
         r_rem   <= '0;
      end else begin
         case (r_state)
            SHIFT: begin
               r_rem  <= rem_step(r_rem, r_word[WORD_W-1]);
               r_word <= r_word << 1;
               if (r_cnt == '0) r_state <= REPORT;
               else             r_cnt   <= r_cnt - 1'b1;
            end
            REPORT: if (res_ready) r_state <= IDLE;
            default: ;
         endcase
      end
   end

   assign res_valid = (r_state == REPORT);
   assign res_id    = r_id;
   assign res_rem   = r_rem;
   assign res_div   = res_valid && (r_rem == '0);
   assign busy      = (r_state != IDLE);

`ifdef MOD7_DIV_CNT_EN
   logic [DIV_CNT_W-1:0] r_div_cnt;

   always_ff @(posedge clk) begin
      if (rst)
         r_div_cnt <= '0;
      else if (w_res_hs && res_div && (r_div_cnt != '1))
         r_div_cnt <= r_div_cnt + 1'b1;
   end

   assign div_cnt = r_div_cnt;
`else
   // Counter absent: results are only reported on the result port.
`endif

endmodule

// File: tb/tb_mod7_frame_sched.sv
// Bench for mod7_frame_sched: round-robin/timing reference model plus a mod-7 result scoreboard.
module tb_mod7_frame_sched;

   localparam int NUM_REQ = 4;
   localparam int WORD_W  = 16;
   localparam int ID_W    = 2;
   localparam int DW      = NUM_REQ * WORD_W;
   localparam int LAT     = WORD_W + 1;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NUM_REQ-1:0]   req_valid;
   logic [DW-1:0]        req_data;
   logic [NUM_REQ-1:0]   req_ready;
   logic                 res_valid;
   logic                 res_ready;
   logic [ID_W-1:0]      res_id;
   logic [2:0]           res_rem;
   logic                 res_div;
   logic                 busy;
`ifdef MOD7_DIV_CNT_EN
   logic [15:0]          div_cnt;
`endif

   always #5 clk = ~clk;

   mod7_frame_sched #(
      .NUM_REQ (NUM_REQ),
      .WORD_W  (WORD_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_id    (res_id),
      .res_rem   (res_rem),
      .res_div   (res_div),
      .busy      (busy)
`ifdef MOD7_DIV_CNT_EN
      ,
      .div_cnt   (div_cnt)
`endif
   );

   typedef struct { int id; int rem; } exp_t;
   typedef struct { int id; int cyc; } acc_t;

   exp_t sb[$];
   acc_t dut_log[$];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int n_res   = 0;
   int n_acc   = 0;
   int m_phase = 0;   // 0 idle, 1 shift, 2 report
   int m_left  = 0;
   int m_ptr   = 0;
   int wait_g[NUM_REQ];
   logic [NUM_REQ-1:0] acc_mask;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int ptr);
      for (int k = 0; k < NUM_REQ; k++)
         if (((v >> ((ptr + k) % NUM_REQ)) & NUM_REQ'(1)) != '0) return (ptr + k) % NUM_REQ;
      return -1;
   endfunction

   function automatic int oh_idx(input logic [NUM_REQ-1:0] v);
      for (int k = 0; k < NUM_REQ; k++)
         if (((v >> k) & NUM_REQ'(1)) != '0) return k;
      return -1;
   endfunction

   function automatic int word_of(input int i);
      logic [WORD_W-1:0] w;
      w = WORD_W'(req_data >> (i * WORD_W));
      return int'(w);
   endfunction

   task automatic set_word(input int i, input logic [WORD_W-1:0] w);
      req_data = (req_data & ~(DW'({WORD_W{1'b1}}) << (i * WORD_W))) | (DW'(w) << (i * WORD_W));
   endtask

   function automatic logic [WORD_W-1:0] rnd_word();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return WORD_W'(7 * $urandom_range(0, 9362));
         2:       return '1;
         default: return WORD_W'($urandom);
      endcase
   endfunction

   // Runs at the falling edge: check outputs against the model, then advance the model.
   task automatic model_cycle();
      logic [NUM_REQ-1:0] exp_rdy;
      logic [NUM_REQ-1:0] dut_acc;
      logic               hs;
      int                 g;
      int                 d;
      exp_t               e;
      exp_rdy = '0;
      g       = -1;
      hs      = (m_phase == 2) && res_ready;
      if (m_phase == 0 || hs) begin
         g = rr_pick(req_valid, m_ptr);
         if (g >= 0) exp_rdy = NUM_REQ'(1) << g;
      end
      if (!rst) chk("req_ready", req_ready, exp_rdy);
      chk("res_valid", res_valid, m_phase == 2);
      chk("busy", busy, m_phase != 0);
      if (m_phase == 2 && sb.size() > 0) begin
         chk("res_id", res_id, sb[0].id);
         chk("res_rem", res_rem, sb[0].rem);
         chk("res_div", res_div, sb[0].rem == 0);
      end
      acc_mask = '0;
      dut_acc  = req_valid & req_ready;
      if (rst) begin
         m_phase = 0;
         m_ptr   = 0;
         sb.delete();
         for (int i = 0; i < NUM_REQ; i++) wait_g[i] = 0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++)
            if (((req_valid >> i) & NUM_REQ'(1)) == '0) wait_g[i] = 0;
         if (dut_acc != '0) begin
            d = oh_idx(dut_acc);
            n_acc++;
            dut_log.push_back('{d, cyc});
            chk("starve", wait_g[d] <= NUM_REQ - 1, 1'b1);
            for (int i = 0; i < NUM_REQ; i++)
               if (i == d) wait_g[i] = 0;
               else if (((req_valid >> i) & NUM_REQ'(1)) != '0) wait_g[i]++;
         end
         if (hs) begin
            if (sb.size() > 0) void'(sb.pop_front());
            n_res++;
         end
         if (g >= 0) begin
            e.id  = g;
            e.rem = word_of(g) % 7;
            sb.push_back(e);
            acc_mask = exp_rdy;
            m_ptr    = (g + 1) % NUM_REQ;
            m_phase  = 1;
            m_left   = WORD_W;
         end else if (hs) begin
            m_phase = 0;
         end else if (m_phase == 1) begin
            m_left--;
            if (m_left == 0) m_phase = 2;
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      model_cycle();
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      req_valid = '0;
      res_ready = 1'b1;
      while (busy && n < 4 * LAT) begin
         step();
         n++;
      end
      chk("drain_idle", busy, 1'b0);
      chk("sb_empty", sb.size(), 0);
   endtask

   task automatic send_one(input int id, input logic [WORD_W-1:0] w, input int exp_rem, input string tag);
      int lat;
      req_data  = DW'(w) << (id * WORD_W);
      req_valid = NUM_REQ'(1) << id;
      res_ready = 1'b1;
      step();
      req_valid = '0;
      req_data  = '1;
      lat = 1;
      while (!res_valid && lat < 4 * LAT) begin
         step();
         lat++;
      end
      chk({tag, "_lat"}, lat, LAT);
      chk({tag, "_id"}, res_id, id);
      chk({tag, "_rem"}, res_rem, exp_rem);
      chk({tag, "_div"}, res_div, exp_rem == 0);
      step();
   endtask

   initial begin
      int n;
      int last;
      int acc0;
      int res0;
      rst       = 1'b1;
      req_valid = '0;
      req_data  = '0;
      res_ready = 1'b1;
      acc_mask  = '0;
      for (int i = 0; i < NUM_REQ; i++) wait_g[i] = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_res_valid", res_valid, 1'b0);
      chk("rst_res_id", res_id, 0);
      chk("rst_res_rem", res_rem, 0);
      chk("rst_res_div", res_div, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_req_ready", req_ready, 0);
      step();
      rst = 1'b0;

      send_one(2, 16'h0064, 2, "w100");
      send_one(2, 16'h0007, 0, "w7");
      send_one(2, 16'hFFFF, 1, "wffff");
      send_one(2, 16'h0000, 0, "w0");

      // all four requesters held valid: 0,1,2,3,0 at one grant per LAT cycles
      rst = 1'b1;
      step();
      rst = 1'b0;
      req_data = '0;
      for (int i = 0; i < NUM_REQ; i++) set_word(i, WORD_W'(i * 4321 + 17));
      req_valid = '1;
      res_ready = 1'b1;
      dut_log.delete();
      n = 0;
      while (dut_log.size() < 5 && n < 8 * LAT) begin
         step();
         n++;
      end
      if (dut_log.size() >= 5) begin
         for (int k = 0; k < 5; k++) begin
            chk("rr_order", dut_log[k].id, k % NUM_REQ);
            if (k > 0) chk("rr_period", dut_log[k].cyc - dut_log[k-1].cyc, LAT);
         end
      end else begin
         chk("rr_count", dut_log.size(), 5);
      end

      // backpressure on the result of requester 0
      n = 0;
      while (!res_valid && n < 4 * LAT) begin
         step();
         n++;
      end
      res_ready = 1'b0;
      repeat (5) step();
      chk("bp_valid", res_valid, 1'b1);
      chk("bp_ready", req_ready, 0);
      res_ready = 1'b1;
      last = dut_log.size();
      step();
      if (dut_log.size() > last) chk("bp_next_grant", dut_log[dut_log.size()-1].id, 1);
      else                       chk("bp_grant_seen", dut_log.size(), last + 1);
      drain();

      // reset during SHIFT discards the frame and returns the pointer to 0
      req_data  = DW'(16'h1234) << (2 * WORD_W);
      req_valid = 4'b0100;
      step();
      req_valid = '0;
      repeat (8) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_valid", res_valid, 1'b0);
      chk("mid_rst_busy", busy, 1'b0);
      req_valid = 4'b1011;
      #1;
      chk("mid_rst_grant", req_ready, 4'b0001);
      step();
      drain();

      // random traffic with random result backpressure
      acc0 = n_acc;
      res0 = n_res;
      n = 0;
      while ((n_acc - acc0) < 1000 && n < 60000) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (((acc_mask >> i) & NUM_REQ'(1)) != '0) begin
               set_word(i, rnd_word());
               if ($urandom_range(0, 1) == 0) req_valid[i] = 1'b0;
            end else if (!req_valid[i]) begin
               if ($urandom_range(0, 3) == 0) begin
                  set_word(i, rnd_word());
                  req_valid[i] = 1'b1;
               end
            end else if ($urandom_range(0, 63) == 0) begin
               req_valid[i] = 1'b0;
            end
         end
         res_ready = ($urandom_range(0, 3) != 0);
         step();
         n++;
      end
      chk("rand_words", (n_acc - acc0) >= 1000, 1'b1);
      drain();
      chk("rand_no_loss", n_res - res0, n_acc - acc0);

`ifdef MOD7_DIV_CNT_EN
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("dc_reset", div_cnt, 0);
      send_one(1, 16'h0007, 0, "dc7a");
      send_one(1, 16'h0007, 0, "dc7b");
      send_one(1, 16'h0064, 2, "dc100");
      send_one(1, 16'h0007, 0, "dc7c");
      chk("dc_count", div_cnt, 3);
      force dut.r_div_cnt = 16'hFFFF;
      step();
      release dut.r_div_cnt;
      send_one(1, 16'h0007, 0, "dc7sat");
      chk("dc_sat", div_cnt, 16'hFFFF);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
